// File: rtl/bp_fe_ras_stack_pkg.sv
// bp_fe_ras_stack_pkg: shared return-address-stack types, checkpoint struct macro and op decode
`ifndef BP_FE_RAS_CKPT_MACRO
`define BP_FE_RAS_CKPT_MACRO
`define DECLARE_BP_FE_RAS_CKPT_S(ptr_width) \
  typedef struct packed { \
    logic [ptr_width-1:0] ptr; \
    logic [ptr_width:0]   count; \
  } bp_fe_ras_ckpt_s;
`endif

package bp_fe_ras_stack_pkg;

  typedef enum logic [2:0] {
    e_ras_none,
    e_ras_clear,
    e_ras_restore,
    e_ras_push,
    e_ras_pop,
    e_ras_swap
  } bp_fe_ras_op_e;

  function automatic bp_fe_ras_op_e ras_op_decode(input logic clear, restore, push, pop);
    return clear ? e_ras_clear
         : restore ? e_ras_restore
         : (push & pop) ? e_ras_swap
         : push ? e_ras_push
         : pop ? e_ras_pop
         : e_ras_none;
  endfunction

endpackage

// File: rtl/bp_fe_ras_stack.sv
// bp_fe_ras_stack: multi-entry return address stack with checkpoint/restore of {ptr, count}
module bp_fe_ras_stack
  import bp_fe_ras_stack_pkg::*;
 #(parameter int vaddr_width_p = 39
  ,parameter int ras_depth_p = 8
  ,localparam int ras_ptr_width_lp = $clog2(ras_depth_p)
  ,localparam int ras_ckpt_width_lp = 2*ras_ptr_width_lp+1
  )
  (input  logic                         clk_i
  ,input  logic                         reset_n_i
  ,input  logic                         clear_i
  ,input  logic                         push_v_i
  ,input  logic [vaddr_width_p-1:0]     push_addr_i
  ,input  logic                         pop_v_i
  ,output logic [vaddr_width_p-1:0]     top_addr_o
  ,output logic                         top_v_o
  ,output logic [ras_ckpt_width_lp-1:0] ckpt_o
  ,input  logic                         restore_v_i
  ,input  logic [ras_ckpt_width_lp-1:0] restore_ckpt_i
  );

  `DECLARE_BP_FE_RAS_CKPT_S(ras_ptr_width_lp)

  localparam logic [ras_ptr_width_lp:0] depth_lp = (ras_ptr_width_lp+1)'(ras_depth_p);
  localparam logic [ras_ptr_width_lp:0] one_lp = (ras_ptr_width_lp+1)'(1);

  bp_fe_ras_ckpt_s state_r, state_n;
  logic [vaddr_width_p-1:0] mem_r [ras_depth_p];
  bp_fe_ras_op_e op;
  logic [ras_ptr_width_lp-1:0] ptr_inc, ptr_dec, wr_idx;
  logic wr_v;

  assign op = ras_op_decode(clear_i, restore_v_i, push_v_i, pop_v_i);
  assign ptr_inc = state_r.ptr + 1'b1;
  assign ptr_dec = state_r.ptr - 1'b1;

  assign top_addr_o = mem_r[state_r.ptr];
  assign top_v_o = |state_r.count;
  assign ckpt_o = state_r;

  always_comb begin
    state_n = state_r;
    wr_v = (op == e_ras_push) | (op == e_ras_swap);
    wr_idx = (op == e_ras_swap) ? state_r.ptr : ptr_inc;
    case (op)
      e_ras_clear: state_n = '0;
      e_ras_restore: state_n = restore_ckpt_i;
      e_ras_push: begin
        state_n.ptr = ptr_inc;
        state_n.count = (state_r.count == depth_lp) ? depth_lp : state_r.count + 1'b1;
      end
      e_ras_pop: begin
        state_n.ptr = top_v_o ? ptr_dec : state_r.ptr;
        state_n.count = top_v_o ? state_r.count - 1'b1 : state_r.count;
      end
      e_ras_swap: state_n.count = top_v_o ? state_r.count : one_lp;
      default: state_n = state_r;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) state_r <= '0;
    else state_r <= state_n;

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) for (int i = 0; i < ras_depth_p; i++) mem_r[i] <= '0;
    else if (wr_v) mem_r[wr_idx] <= push_addr_i;

endmodule

// File: tb/tb_bp_fe_ras_stack.sv
// tb_bp_fe_ras_stack: table vectors, corner sequences and randomized run against a queue-free array model
module tb_bp_fe_ras_stack;
  localparam int W = 39, D = 8, PW = 3, CW = 7;

  logic clk = 1'b0, reset_n = 1'b0, clear = 1'b0, push_v = 1'b0, pop_v = 1'b0, restore_v = 1'b0;
  logic [W-1:0] push_addr = '0;
  logic [CW-1:0] restore_ckpt = '0;
  logic [W-1:0] top_addr;
  logic top_v;
  logic [CW-1:0] ckpt;
  int n_chk = 0, n_fail = 0;

  logic [W-1:0] m_mem [D];
  int m_ptr, m_cnt;

  typedef struct {
    logic clr, rst, psh, pp;
    logic [CW-1:0] rck;
    logic [W-1:0] addr, e_top;
    logic e_v;
    int e_ptr, e_cnt;
  } vec_t;
  vec_t vecs [14];

  always #5 clk = ~clk;

  bp_fe_ras_stack #(.vaddr_width_p(W), .ras_depth_p(D)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .clear_i(clear), .push_v_i(push_v),
    .push_addr_i(push_addr), .pop_v_i(pop_v), .top_addr_o(top_addr), .top_v_o(top_v),
    .ckpt_o(ckpt), .restore_v_i(restore_v), .restore_ckpt_i(restore_ckpt)
  );

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] pack(input int p, input int c);
    return {PW'(p), (PW+1)'(c)};
  endfunction

  function automatic vec_t mk(input logic clr, rst, input logic [CW-1:0] rck, input logic psh,
                              input logic [W-1:0] a, input logic pp, input logic [W-1:0] e_top,
                              input logic e_v, input int e_ptr, input int e_cnt);
    vec_t v;
    v.clr = clr; v.rst = rst; v.rck = rck; v.psh = psh; v.addr = a; v.pp = pp;
    v.e_top = e_top; v.e_v = e_v; v.e_ptr = e_ptr; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic model_reset;
    for (int i = 0; i < D; i++) m_mem[i] = '0;
    m_ptr = 0;
    m_cnt = 0;
  endtask

  task automatic model_step(input logic clr, rst, input logic [CW-1:0] rck, input logic psh,
                            input logic [W-1:0] a, input logic pp);
    if (clr) begin
      m_ptr = 0; m_cnt = 0;
    end else if (rst) begin
      m_ptr = int'(rck[CW-1:PW+1]); m_cnt = int'(rck[PW:0]);
    end else if (psh && pp) begin
      m_mem[m_ptr] = a;
      if (m_cnt == 0) m_cnt = 1;
    end else if (psh) begin
      m_ptr = (m_ptr + 1) % D;
      m_mem[m_ptr] = a;
      if (m_cnt < D) m_cnt++;
    end else if (pp && m_cnt > 0) begin
      m_ptr = (m_ptr + D - 1) % D;
      m_cnt--;
    end
  endtask

  task automatic check_model(input string nm);
    cmp({nm, " top_addr"}, top_addr, m_mem[m_ptr]);
    cmp({nm, " top_v"}, top_v, m_cnt != 0);
    cmp({nm, " ckpt"}, ckpt, pack(m_ptr, m_cnt));
  endtask

  task automatic step(input logic clr, rst, input logic [CW-1:0] rck, input logic psh,
                      input logic [W-1:0] a, input logic pp);
    clear = clr; restore_v = rst; restore_ckpt = rck; push_v = psh; push_addr = a; pop_v = pp;
    @(posedge clk);
    model_step(clr, rst, rck, psh, a, pp);
    #1;
    clear = 1'b0; restore_v = 1'b0; push_v = 1'b0; pop_v = 1'b0;
  endtask

  logic [CW-1:0] ck;
  logic [CW-1:0] ck_q [$];

  initial begin
    model_reset();
    #3;
    cmp("reset top_addr", top_addr, 0);
    cmp("reset top_v", top_v, 0);
    cmp("reset ckpt", ckpt, 0);
    reset_n = 1'b1;

    vecs[0]  = mk(1'b0, 1'b0, '0,    1'b1, 39'h1000, 1'b0, 39'h1000, 1'b1, 1, 1);
    vecs[1]  = mk(1'b0, 1'b0, '0,    1'b1, 39'h2000, 1'b0, 39'h2000, 1'b1, 2, 2);
    vecs[2]  = mk(1'b0, 1'b0, '0,    1'b1, 39'h3000, 1'b0, 39'h3000, 1'b1, 3, 3);
    vecs[3]  = mk(1'b0, 1'b0, '0,    1'b0, 39'h0,    1'b1, 39'h2000, 1'b1, 2, 2);
    vecs[4]  = mk(1'b0, 1'b0, '0,    1'b0, 39'h0,    1'b1, 39'h1000, 1'b1, 1, 1);
    vecs[5]  = mk(1'b0, 1'b0, '0,    1'b0, 39'h0,    1'b1, 39'h0,    1'b0, 0, 0);
    vecs[6]  = mk(1'b0, 1'b0, '0,    1'b0, 39'h0,    1'b1, 39'h0,    1'b0, 0, 0);
    vecs[7]  = mk(1'b0, 1'b0, '0,    1'b1, 39'hA0,   1'b0, 39'hA0,   1'b1, 1, 1);
    vecs[8]  = mk(1'b0, 1'b0, '0,    1'b1, 39'h2000, 1'b0, 39'h2000, 1'b1, 2, 2);
    vecs[9]  = mk(1'b0, 1'b0, '0,    1'b1, 39'h5000, 1'b1, 39'h5000, 1'b1, 2, 2);
    vecs[10] = mk(1'b0, 1'b0, '0,    1'b0, 39'h0,    1'b1, 39'hA0,   1'b1, 1, 1);
    vecs[11] = mk(1'b0, 1'b0, '0,    1'b0, 39'h0,    1'b1, 39'h0,    1'b0, 0, 0);
    vecs[12] = mk(1'b0, 1'b0, '0,    1'b1, 39'h5000, 1'b1, 39'h5000, 1'b1, 0, 1);
    vecs[13] = mk(1'b1, 1'b1, 7'h33, 1'b1, 39'h77,   1'b0, 39'h5000, 1'b0, 0, 0);

    for (int i = 0; i < 14; i++) begin
      step(vecs[i].clr, vecs[i].rst, vecs[i].rck, vecs[i].psh, vecs[i].addr, vecs[i].pp);
      cmp($sformatf("vec%0d top_addr", i), top_addr, vecs[i].e_top);
      cmp($sformatf("vec%0d top_v", i), top_v, vecs[i].e_v);
      cmp($sformatf("vec%0d ckpt", i), ckpt, pack(vecs[i].e_ptr, vecs[i].e_cnt));
    end

    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    for (int k = 1; k <= 9; k++) step(1'b0, 1'b0, '0, 1'b1, W'(k * 'h100), 1'b0);
    cmp("overflow ckpt", ckpt, pack(1, 8));
    cmp("overflow top", top_addr, 39'h900);
    for (int k = 0; k < 8; k++) begin
      cmp($sformatf("drain top%0d", k), top_addr, W'('h900 - k * 'h100));
      step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    end
    cmp("drained ckpt", ckpt, pack(1, 0));
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    cmp("underflow ckpt", ckpt, pack(1, 0));
    cmp("underflow top_v", top_v, 0);
    check_model("after drain");

    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 39'hA, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 39'hB, 1'b0);
    ck = ckpt;
    step(1'b0, 1'b0, '0, 1'b1, 39'hC, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 39'hD, 1'b0);
    step(1'b0, 1'b1, ck, 1'b1, 39'hE, 1'b0);
    cmp("restore top", top_addr, 39'hB);
    cmp("restore ckpt", ckpt, pack(2, 2));

    step(1'b1, 1'b1, ck, 1'b1, 39'h77, 1'b0);
    cmp("clear prio ckpt", ckpt, 0);
    cmp("clear prio top_v", top_v, 0);

    step(1'b0, 1'b0, '0, 1'b1, 39'h11, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 39'h22, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    cmp("async reset top_addr", top_addr, 0);
    cmp("async reset top_v", top_v, 0);
    cmp("async reset ckpt", ckpt, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    check_model("post reset");

    for (int n = 0; n < 1500; n++) begin
      int r;
      logic rst;
      r = int'($urandom_range(0, 99));
      ck_q.push_back(pack(m_ptr, m_cnt));
      if (ck_q.size() > 16) void'(ck_q.pop_front());
      rst = (r >= 3 && r < 10);
      ck = ck_q[$urandom_range(0, ck_q.size() - 1)];
      step(r < 3, rst, ck, 1'($urandom), W'({$urandom, $urandom}), 1'($urandom));
      check_model($sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
